// File: rtl/img_patch_fetch.sv
// 2x2 neighbourhood fetcher for the bilinear interpolator: four clamped reads from a
// 1-cycle-latency image RAM, then a held patch on a valid/ready port. Optional: PATCH_FLAT_DETECT_EN.
module img_patch_fetch #(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int COORD_W   = 8,
  parameter int ADDR_W    = 12,
  parameter int FRAC_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [COORD_W-1:0]   req_row,
  input  logic [COORD_W-1:0]   req_col,
  input  logic [FRAC_BITS-1:0] req_frac_r,
  input  logic [FRAC_BITS-1:0] req_frac_c,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [7:0]           mem_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          row0_ele,
  output logic [15:0]          row1_ele,
  output logic [FRAC_BITS-1:0] out_frac_r,
  output logic [FRAC_BITS-1:0] out_frac_c,
  output logic                 out_flat,
  output logic [2:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // valid is never withdrawn before its transfer; data is held stable while valid waits.

  localparam int CW = COORD_W + 1;
  localparam logic [COORD_W:0] MAX_R = CW'(IMG_H - 1);
  localparam logic [COORD_W:0] MAX_C = CW'(IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD00 = 3'd1,
    S_RD01 = 3'd2,
    S_RD10 = 3'd3,
    S_RD11 = 3'd4,
    S_LAST = 3'd5,
    S_HOLD = 3'd6
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_mem_rd_en;
  logic [ADDR_W-1:0]     r_mem_rd_addr;
  logic                  r_out_valid;
  logic [7:0]            r_ele00, r_ele01, r_ele10, r_ele11;
  logic [FRAC_BITS-1:0]  r_frac_r, r_frac_c;
  logic [COORD_W:0]      r_row, r_row1, r_col, r_col1;

  logic [COORD_W:0]      w_row_ext, w_col_ext;
  logic [COORD_W:0]      w_row_c, w_col_c, w_row_n, w_col_n;
  logic [ADDR_W-1:0]     w_addr00;

  // Low ADDR_W bits of the product are the same whether formed in ADDR_W or ADDR_W+1 bits.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W:0] row,
                                                  input logic [COORD_W:0] col);
    return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  endfunction

  // One extra bit keeps r=255 from wrapping when clamping and incrementing.
  assign w_row_ext = {1'b0, req_row};
  assign w_col_ext = {1'b0, req_col};
  assign w_row_c   = (w_row_ext > MAX_R) ? MAX_R : w_row_ext;
  assign w_col_c   = (w_col_ext > MAX_C) ? MAX_C : w_col_ext;
  assign w_row_n   = (w_row_c >= MAX_R) ? MAX_R : w_row_c + 1'b1;
  assign w_col_n   = (w_col_c >= MAX_C) ? MAX_C : w_col_c + 1'b1;
  assign w_addr00  = pix_addr(w_row_c, w_col_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_out_valid   <= 1'b0;
      r_ele00       <= '0;
      r_ele01       <= '0;
      r_ele10       <= '0;
      r_ele11       <= '0;
      r_frac_r      <= '0;
      r_frac_c      <= '0;
      r_row         <= '0;
      r_row1        <= '0;
      r_col         <= '0;
      r_col1        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_row         <= w_row_c;
            r_row1        <= w_row_n;
            r_col         <= w_col_c;
            r_col1        <= w_col_n;
            r_frac_r      <= req_frac_r;
            r_frac_c      <= req_frac_c;
            r_mem_rd_en   <= 1'b1;
            r_mem_rd_addr <= w_addr00;
            r_req_ready   <= 1'b0;
            r_state       <= S_RD00;
          end else begin
            r_req_ready   <= 1'b1;
          end
        end
        S_RD00: begin
          r_mem_rd_addr <= pix_addr(r_row, r_col1);
          r_state       <= S_RD01;
        end
        // Read data trails the address by one cycle, so each capture lags its issue state.
        S_RD01: begin
          r_ele00       <= mem_rd_data;
          r_mem_rd_addr <= pix_addr(r_row1, r_col);
          r_state       <= S_RD10;
        end
        S_RD10: begin
          r_ele01       <= mem_rd_data;
          r_mem_rd_addr <= pix_addr(r_row1, r_col1);
          r_state       <= S_RD11;
        end
        S_RD11: begin
          r_ele10     <= mem_rd_data;
          r_mem_rd_en <= 1'b0;
          r_state     <= S_LAST;
        end
        S_LAST: begin
          r_ele11     <= mem_rd_data;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_mem_rd_en <= 1'b0;
          r_out_valid <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PATCH_FLAT_DETECT_EN
  logic r_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flat <= 1'b0;
    end else if (r_state == S_LAST) begin
      r_flat <= (r_ele00 == r_ele01) && (r_ele00 == r_ele10) && (r_ele00 == mem_rd_data);
    end else if (r_state == S_HOLD && out_ready) begin
      r_flat <= 1'b0;
    end
  end

  assign out_flat = r_flat;
`else
  assign out_flat = 1'b0;
`endif

  assign req_ready   = r_req_ready;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;
  assign out_valid   = r_out_valid;
  assign row0_ele    = {r_ele00, r_ele01};
  assign row1_ele    = {r_ele10, r_ele11};
  assign out_frac_r  = r_frac_r;
  assign out_frac_c  = r_frac_c;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_img_patch_fetch.sv
// Bench for img_patch_fetch: RAM model P(r,c)=(3r+c)&FF, address and patch scoreboards,
// scenario tasks for reset, interior, clamping, backpressure, mid-fetch reset and back-to-back.
module tb_img_patch_fetch;

  localparam int W = 37;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_row, req_col;
  logic [1:0]  req_frac_r, req_frac_c;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] row0_ele, row1_ele;
  logic [1:0]  out_frac_r, out_frac_c;
  logic        out_flat;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0]  addr_q[$];
  logic [W-1:0] exp_q[$];

  img_patch_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col),
    .req_frac_r(req_frac_r), .req_frac_c(req_frac_c),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .row0_ele(row0_ele), .row1_ele(row1_ele),
    .out_frac_r(out_frac_r), .out_frac_c(out_frac_c),
    .out_flat(out_flat), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r * 3 + c) & 255);
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= pix(int'(mem_rd_addr) / 64, int'(mem_rd_addr) % 64);
  end

  // ---------------- model / scoreboard ----------------
  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic push_expect(input int r, input int c, input int fr, input int fc);
    int rr, cc, r1, c1;
    logic [7:0] e00, e01, e10, e11;
    logic flat;
    rr = clampi(r, 63);
    cc = clampi(c, 63);
    r1 = clampi(rr + 1, 63);
    c1 = clampi(cc + 1, 63);
    addr_q.push_back(12'(rr * 64 + cc));
    addr_q.push_back(12'(rr * 64 + c1));
    addr_q.push_back(12'(r1 * 64 + cc));
    addr_q.push_back(12'(r1 * 64 + c1));
    e00 = pix(rr, cc);
    e01 = pix(rr, c1);
    e10 = pix(r1, cc);
    e11 = pix(r1, c1);
`ifdef PATCH_FLAT_DETECT_EN
    flat = (e00 == e01) && (e00 == e10) && (e00 == e11);
`else
    flat = 1'b0;
`endif
    exp_q.push_back({e00, e01, e10, e11, 2'(fr), 2'(fc), flat});
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_rd_en === 1'b1) begin
      n_tests++;
      if (addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_addr: unexpected read addr=%0d, none expected", mem_rd_addr);
      end else begin
        logic [11:0] ea;
        ea = addr_q.pop_front();
        if (mem_rd_addr !== ea) begin
          n_fail++;
          $display("FAIL rd_addr: got %0d expected %0d", mem_rd_addr, ea);
        end
      end
    end
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL patch: unexpected patch row0=%h row1=%h", row0_ele, row1_ele);
      end else begin
        logic [W-1:0] ep;
        ep = exp_q.pop_front();
        if ({row0_ele, row1_ele, out_frac_r, out_frac_c, out_flat} !== ep) begin
          n_fail++;
          $display("FAIL patch: got row0=%h row1=%h fr=%0d fc=%0d flat=%0d expected row0=%h row1=%h fr=%0d fc=%0d flat=%0d",
                   row0_ele, row1_ele, out_frac_r, out_frac_c, out_flat,
                   ep[36:21], ep[20:5], ep[4:3], ep[2:1], ep[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input int r, input int c, input int fr, input int fc);
    int n;
    req_row    = 8'(r);
    req_col    = 8'(c);
    req_frac_r = 2'(fr);
    req_frac_c = 2'(fc);
    req_valid  = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL req_accept: req_ready stayed %b for %0d cycles, required 1", req_ready, n);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      push_expect(r, c, fr, fc);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int lat);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n >= 40) begin
      n_fail++;
      $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
    end
    lat = n;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b0 || mem_rd_en !== 1'b0 || mem_rd_addr !== 12'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b rd_en=%b addr=%0d ov=%b required 0/0/0/0",
               req_ready, mem_rd_en, mem_rd_addr, out_valid);
    end
    n_tests++;
    if (row0_ele !== 16'h0 || row1_ele !== 16'h0 || out_frac_r !== 2'd0 || out_frac_c !== 2'd0 ||
        out_flat !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_data: got row0=%h row1=%h fr=%0d fc=%0d flat=%b st=%0d required all 0",
               row0_ele, row1_ele, out_frac_r, out_frac_c, out_flat, dbg_state);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_interior();
    int lat;
    out_ready = 1'b1;
    send_req(10, 20, 1, 2);
    wait_out(lat);
    n_tests++;
    if (lat + 1 != 6) begin
      n_fail++;
      $display("FAIL latency: got cycle %0d required 6", lat + 1);
    end
    n_tests++;
    if (row0_ele !== 16'h3233 || row1_ele !== 16'h3536 || out_frac_r !== 2'd1 || out_frac_c !== 2'd2) begin
      n_fail++;
      $display("FAIL interior: got row0=%h row1=%h fr=%0d fc=%0d required 3233 3536 1 2",
               row0_ele, row1_ele, out_frac_r, out_frac_c);
    end
    drain();
  endtask

  task automatic test_clamp(input int r, input int c, input int fr, input int fc);
    int lat;
    logic exp_flat;
`ifdef PATCH_FLAT_DETECT_EN
    exp_flat = 1'b1;
`else
    exp_flat = 1'b0;
`endif
    out_ready = 1'b1;
    send_req(r, c, fr, fc);
    wait_out(lat);
    n_tests++;
    if (row0_ele !== 16'hFCFC || row1_ele !== 16'hFCFC || out_flat !== exp_flat) begin
      n_fail++;
      $display("FAIL clamp(%0d,%0d): got row0=%h row1=%h flat=%b required FCFC FCFC %b",
               r, c, row0_ele, row1_ele, out_flat, exp_flat);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] s0, s1;
    out_ready = 1'b0;
    send_req(1, 2, 2, 1);
    wait_out(lat);
    s0 = row0_ele;
    s1 = row1_ele;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        req_row = 8'd7; req_col = 8'd7; req_valid = 1'b1;
      end
      if (i == 5) req_valid = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || req_ready !== 1'b0 || row0_ele !== s0 || row1_ele !== s1 ||
          dbg_state !== 3'd6) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got ov=%b rdy=%b row0=%h row1=%h st=%0d required 1 0 %h %h 6",
                 i, out_valid, req_ready, row0_ele, row1_ele, dbg_state, s0, s1);
      end
    end
    drain();
    n_tests++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got ready=%b ov=%b required 1 0", req_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int lat;
    out_ready = 1'b1;
    send_req(5, 5, 1, 1);
    @(posedge clk);
    @(posedge clk); #1;
    n_tests++;
    if (dbg_state !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_state: got %0d required 3", dbg_state);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_rd_en !== 1'b0 || mem_rd_addr !== 12'd0 || out_valid !== 1'b0 || req_ready !== 1'b0 ||
        row0_ele !== 16'h0 || row1_ele !== 16'h0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: got rd_en=%b addr=%0d ov=%b rdy=%b row0=%h row1=%h st=%0d required zeros",
               mem_rd_en, mem_rd_addr, out_valid, req_ready, row0_ele, row1_ele, dbg_state);
    end
    addr_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_req(0, 0, 0, 0);
    wait_out(lat);
    n_tests++;
    if (row0_ele !== 16'h0001 || row1_ele !== 16'h0304) begin
      n_fail++;
      $display("FAIL post_reset: got row0=%h row1=%h required 0001 0304", row0_ele, row1_ele);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n, lat;
    logic seen;
    out_ready  = 1'b1;
    req_row = 8'd3; req_col = 8'd4; req_frac_r = 2'd0; req_frac_c = 2'd1;
    req_valid  = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk);
    push_expect(3, 4, 0, 1);
    #1;
    req_row = 8'd62; req_col = 8'd63; req_frac_r = 2'd3; req_frac_c = 2'd2;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      seen = req_ready;
      @(posedge clk);
      if (seen) push_expect(62, 63, 3, 2);
      #1;
      n++;
    end
    req_valid = 1'b0;
    n_tests++;
    if (n != 7) begin
      n_fail++;
      $display("FAIL b2b_interval: got %0d cycles required 7", n);
    end
    wait_out(lat);
    drain();
  endtask

  task automatic test_random();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_req($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 3));
      wait_out(lat);
      drain();
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    req_valid = 1'b0; req_row = '0; req_col = '0; req_frac_r = '0; req_frac_c = '0;
    out_ready = 1'b1;
    test_reset();
    test_interior();
    test_clamp(63, 63, 3, 0);
    test_clamp(200, 70, 0, 3);
    test_backpressure();
    test_reset_mid_fetch();
    test_back_to_back();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (addr_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d addrs %0d patches pending required 0 0", addr_q.size(), exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
